// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// mem_arbiter_pkg : shared command codes, I/O addresses and FSM encoding
//                   for the two-port memory arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

   localparam logic [1:0] MNONE  = 2'b00;
   localparam logic [1:0] MREAD  = 2'b01;
   localparam logic [1:0] MWRITE = 2'b11;

   localparam logic [8:0] IO_LED_ADDR = 9'h100;
   localparam logic [8:0] IO_SW_ADDR  = 9'h140;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_ISSUE = 2'd1;
   localparam state_t ST_RDATA = 2'd2;

   // Only the LED register is writable and only the switch port is readable.
   function automatic logic io_unmapped(input logic [1:0] cmd, input logic [8:0] addr);
      return addr[8] && (((cmd == MWRITE) && (addr != IO_LED_ADDR)) ||
                         ((cmd == MREAD)  && (addr != IO_SW_ADDR)));
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// ============================================================================
// rr_arbiter2 : two-way round-robin winner select with its last-winner pointer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arbiter2 (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] req_i,
   input  logic       take_i,
   output logic       win_o
);

   logic last_q;
   logic last_d;

   // On a tie the port that did not win last time goes next.
   always_comb begin
      win_o = (req_i == 2'b11) ? ~last_q : req_i[1];
   end

   always_comb begin
      last_d = take_i ? win_o : last_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : two-requester round-robin sequencer for the shared RAM and
//               switch/LED I/O. Optional MEM_ARBITER_ERR_EN adds bus_err/err_addr.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int DW  = 16,
   parameter int AW  = 9,
   parameter int RAW = 8
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [1:0]      req,
   input  logic [1:0]      cmd0,
   input  logic [1:0]      cmd1,
   input  logic [AW-1:0]   addr0,
   input  logic [AW-1:0]   addr1,
   input  logic [DW-1:0]   wdata0,
   input  logic [DW-1:0]   wdata1,
   output logic [1:0]      gnt,
   output logic [1:0]      rvalid,
   output logic [DW-1:0]   rdata,
   output logic [RAW-1:0]  ram_addr,
   output logic            ram_write,
   output logic [DW-1:0]   ram_din,
   input  logic [DW-1:0]   ram_dout,
   input  logic [7:0]      sw,
`ifdef MEM_ARBITER_ERR_EN
   output logic            bus_err,
   output logic [AW-1:0]   err_addr,
`endif
   output logic [7:0]      led
);

   state_t          state_q;
   state_t          state_d;
   logic            win;
   logic            take;
   logic            win_q;
   logic [1:0]      cmd_q;
   logic [AW-1:0]   addr_q;
   logic [DW-1:0]   wdata_q;
   logic [7:0]      sw_q;
   logic [7:0]      led_q;
   logic            led_wr;
   logic            sw_rd;

   assign take   = (state_q == ST_IDLE) && (|req);
   assign led_wr = (state_q == ST_ISSUE) && (cmd_q == MWRITE) && (addr_q == AW'(IO_LED_ADDR));
   assign sw_rd  = (state_q == ST_ISSUE) && (cmd_q == MREAD)  && (addr_q == AW'(IO_SW_ADDR));
   assign led    = led_q;

   rr_arbiter2 u_rr (
      .clk     (clk),
      .reset_n (reset_n),
      .req_i   (req),
      .take_i  (take),
      .win_o   (win)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (|req) state_d = ST_ISSUE;
         ST_ISSUE: state_d = (cmd_q == MREAD) ? ST_RDATA : ST_IDLE;
         ST_RDATA: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      gnt       = 2'b00;
      rvalid    = 2'b00;
      rdata     = '0;
      ram_addr  = '0;
      ram_write = 1'b0;
      ram_din   = '0;
      case (state_q)
         ST_ISSUE: begin
            gnt[win_q] = 1'b1;
            ram_addr   = addr_q[RAW-1:0];
            if ((cmd_q == MWRITE) && !addr_q[AW-1]) begin
               ram_write = 1'b1;
               ram_din   = wdata_q;
            end
         end
         ST_RDATA: begin
            rvalid[win_q] = 1'b1;
            if (!addr_q[AW-1]) begin
               rdata = ram_dout;
            end else if (addr_q == AW'(IO_SW_ADDR)) begin
               rdata = {{(DW-8){1'b0}}, sw_q};
            end
         end
         default: ;
      endcase
   end

   // The winner's command is captured once so requesters may change after gnt.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         win_q   <= 1'b0;
         cmd_q   <= MNONE;
         addr_q  <= '0;
         wdata_q <= '0;
         sw_q    <= '0;
         led_q   <= '0;
      end else begin
         if (take) begin
            win_q   <= win;
            cmd_q   <= win ? cmd1   : cmd0;
            addr_q  <= win ? addr1  : addr0;
            wdata_q <= win ? wdata1 : wdata0;
         end
         if (led_wr) led_q <= wdata_q[7:0];
         if (sw_rd)  sw_q  <= sw;
      end
   end

`ifdef MEM_ARBITER_ERR_EN
   logic          bus_err_q;
   logic [AW-1:0] err_addr_q;

   assign bus_err  = bus_err_q;
   assign err_addr = err_addr_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus_err_q  <= 1'b0;
         err_addr_q <= '0;
      end else if ((state_q == ST_ISSUE) && !bus_err_q && io_unmapped(cmd_q, 9'(addr_q))) begin
         bus_err_q  <= 1'b1;
         err_addr_q <= addr_q;
      end
   end
`endif

endmodule

`default_nettype wire
